// File: rtl/uart_hex_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for uart_hex_loader.
// slave = the loader itself, master = the side feeding bytes and watching the write port.
interface uart_hex_loader_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              nibble_pending;
    logic              err_char;
    logic              err_partial;
    logic              overflow;
    logic [WORD_W-1:0] load_xor;

    modport master (
        output rx_data, rx_valid, restart,
        input  mem_we, mem_addr, mem_wdata, word_count, busy, done,
               nibble_pending, err_char, err_partial, overflow, load_xor
    );

    modport slave (
        input  rx_data, rx_valid, restart,
        output mem_we, mem_addr, mem_wdata, word_count, busy, done,
               nibble_pending, err_char, err_partial, overflow, load_xor
    );
endinterface

// File: rtl/uart_hex_loader.sv
// ASCII-hex program loader: assembles hex digits (MSB nibble first) into words and writes them out.
// Optional running XOR of written words is built only when UART_HEX_LOADER_XOR_EN is defined.
module uart_hex_loader #(
    parameter int WORD_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 500000000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    uart_hex_loader_if.slave bus
);
    localparam int NIB_N = WORD_W / 4;
    localparam int NIB_W = $clog2(NIB_N + 1);
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB_N - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] shift_q;
    logic [NIB_W-1:0]  nib_cnt_q;
    logic [CNT_W-1:0]  tmo_q;
    logic [ADDR_W:0]   word_count_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_char_q;
    logic              err_partial_q;
    logic              overflow_q;

    logic              is_hex;
    logic              is_sep;
    logic [3:0]        nibble;
    logic [WORD_W-1:0] word_d;
    logic              digit_fire;
    logic              word_fire;
    logic              mem_full;
    logic              write_fire;

    always_comb begin
        is_hex = 1'b1;
        nibble = 4'h0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            nibble = bus.rx_data[3:0];
        end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            nibble = bus.rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
        is_sep = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) ||
                 (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h2C) ||
                 (bus.rx_data == 8'h09);
    end

    assign word_d     = (shift_q << 4) | WORD_W'(nibble);
    assign digit_fire = bus.rx_valid && is_hex && (state_q != S_DONE) && !bus.restart;
    assign word_fire  = digit_fire && (nib_cnt_q == NIB_LAST);
    assign mem_full   = word_count_q[ADDR_W];
    assign write_fire = word_fire && !mem_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            nib_cnt_q     <= '0;
            tmo_q         <= '0;
            word_count_q  <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_char_q    <= 1'b0;
            err_partial_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (bus.restart) begin
            // mem_addr/mem_wdata keep the last write; everything describing the load clears
            state_q       <= S_IDLE;
            shift_q       <= '0;
            nib_cnt_q     <= '0;
            tmo_q         <= '0;
            word_count_q  <= '0;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_char_q    <= 1'b0;
            err_partial_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        if (is_hex) begin
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                            tmo_q   <= '0;
                        end else if (!is_sep) begin
                            err_char_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.rx_valid) begin
                        tmo_q <= '0;
                        if (!is_hex) begin
                            if (!is_sep) begin
                                err_char_q <= 1'b1;
                            end else if (nib_cnt_q != '0) begin
                                err_partial_q <= 1'b1;
                            end
                            nib_cnt_q <= '0;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tmo_q   <= '0;
                        if (nib_cnt_q != '0) begin
                            err_partial_q <= 1'b1;
                        end
                        nib_cnt_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase

            // Digit path is shared by IDLE (first digit) and LOAD
            if (digit_fire) begin
                shift_q <= word_d;
                if (word_fire) begin
                    nib_cnt_q <= '0;
                    if (mem_full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= word_count_q[ADDR_W-1:0];
                        mem_wdata_q  <= word_d;
                        word_count_q <= word_count_q + (ADDR_W+1)'(1);
                    end
                end else begin
                    nib_cnt_q <= nib_cnt_q + NIB_W'(1);
                end
            end
        end
    end

`ifdef UART_HEX_LOADER_XOR_EN
    logic [WORD_W-1:0] load_xor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_xor_q <= '0;
        end else if (bus.restart) begin
            load_xor_q <= '0;
        end else if (write_fire) begin
            load_xor_q <= load_xor_q ^ word_d;
        end
    end

    assign bus.load_xor = load_xor_q;
`else
    assign bus.load_xor = '0;
`endif

    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.word_count     = word_count_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.nibble_pending = (nib_cnt_q != '0);
    assign bus.err_char       = err_char_q;
    assign bus.err_partial    = err_partial_q;
    assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: an 8-bit/4-deep loader (A) and a 16-bit/16-deep loader (B).
module tb_uart_hex_loader;
    localparam int TMO = 40;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_hex_loader_if #(.WORD_W(8),  .ADDR_W(2)) bus_a ();
    uart_hex_loader_if #(.WORD_W(16), .ADDR_W(4)) bus_b ();

    uart_hex_loader #(.WORD_W(8), .ADDR_W(2), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    uart_hex_loader #(.WORD_W(16), .ADDR_W(4), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    wr_t sb_a[$];
    wr_t sb_b[$];

    // Reference model state, index 0 = A, 1 = B; state 0 idle, 1 load, 2 done
    int          m_state[2];
    int          m_cnt[2];
    int          m_wc[2];
    int          last_samp[2];
    logic [63:0] m_shift[2];
    logic [63:0] m_xor[2];
    bit          m_errc[2];
    bit          m_errp[2];
    bit          m_ovf[2];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int hexval(byte unsigned b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
        return -1;
    endfunction

    function automatic bit is_sep(byte unsigned b);
        return (b == 8'h20) || (b == 8'h0D) || (b == 8'h0A) || (b == 8'h2C) || (b == 8'h09);
    endfunction

    task automatic model_restart(int d);
        m_state[d] = 0; m_cnt[d] = 0; m_wc[d] = 0; m_shift[d] = '0; m_xor[d] = '0;
        m_errc[d] = 1'b0; m_errp[d] = 1'b0; m_ovf[d] = 1'b0;
    endtask

    task automatic model_byte(int d, byte unsigned b);
        int          v;
        int          nibs;
        int          cap;
        logic [63:0] mask;
        wr_t         w;
        nibs = (d == 0) ? 2 : 4;
        cap  = (d == 0) ? 4 : 16;
        mask = (d == 0) ? 64'hFF : 64'hFFFF;
        if (m_state[d] == 2) return;
        v = hexval(b);
        if (v >= 0) begin
            m_state[d] = 1;
            m_shift[d] = ((m_shift[d] << 4) | 64'(v)) & mask;
            m_cnt[d]++;
            if (m_cnt[d] == nibs) begin
                m_cnt[d] = 0;
                if (m_wc[d] == cap) begin
                    m_ovf[d] = 1'b1;
                end else begin
                    w.addr = 64'(m_wc[d]);
                    w.data = m_shift[d];
                    w.cyc  = cyc + 1;
                    if (d == 0) sb_a.push_back(w); else sb_b.push_back(w);
                    m_wc[d]++;
                    m_xor[d] = m_xor[d] ^ m_shift[d];
                end
            end
        end else if (is_sep(b)) begin
            if (m_state[d] == 1 && m_cnt[d] > 0) begin
                m_errp[d] = 1'b1;
                m_cnt[d]  = 0;
            end
        end else begin
            m_errc[d] = 1'b1;
            m_cnt[d]  = 0;
        end
    endtask

    task automatic model_timeout(int d);
        m_state[d] = 2;
        if (m_cnt[d] > 0) m_errp[d] = 1'b1;
        m_cnt[d] = 0;
    endtask

    task automatic drive(int d, bit v, byte unsigned b, bit rs);
        if (d == 0) begin
            bus_a.rx_valid = v; bus_a.rx_data = b; bus_a.restart = rs;
        end else begin
            bus_b.rx_valid = v; bus_b.rx_data = b; bus_b.restart = rs;
        end
    endtask

    task automatic check_status(int d);
        string       p;
        logic [63:0] wc, xr, exr;
        logic        ec, ep, ov, bz, dn, np;
        p = (d == 0) ? "A" : "B";
        if (d == 0) begin
            wc = 64'(bus_a.word_count); xr = 64'(bus_a.load_xor); ec = bus_a.err_char;
            ep = bus_a.err_partial; ov = bus_a.overflow; bz = bus_a.busy; dn = bus_a.done;
            np = bus_a.nibble_pending;
        end else begin
            wc = 64'(bus_b.word_count); xr = 64'(bus_b.load_xor); ec = bus_b.err_char;
            ep = bus_b.err_partial; ov = bus_b.overflow; bz = bus_b.busy; dn = bus_b.done;
            np = bus_b.nibble_pending;
        end
`ifdef UART_HEX_LOADER_XOR_EN
        exr = m_xor[d];
`else
        exr = '0;
`endif
        chk({p, ".word_count"}, wc, 64'(m_wc[d]));
        chk({p, ".err_char"}, 64'(ec), 64'(m_errc[d]));
        chk({p, ".err_partial"}, 64'(ep), 64'(m_errp[d]));
        chk({p, ".overflow"}, 64'(ov), 64'(m_ovf[d]));
        chk({p, ".busy"}, 64'(bz), 64'(m_state[d] == 1));
        chk({p, ".done"}, 64'(dn), 64'(m_state[d] == 2));
        chk({p, ".nibble_pending"}, 64'(np), 64'(m_cnt[d] != 0));
        chk({p, ".load_xor"}, xr, exr);
    endtask

    task automatic send(int d, byte unsigned b);
        @(negedge clk);
        drive(d, 1'b1, b, 1'b0);
        model_byte(d, b);
        last_samp[d] = cyc + 1;
        @(negedge clk);
        drive(d, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_str(int d, string s);
        for (int i = 0; i < s.len(); i++) begin
            send(d, s[i]);
            check_status(d);
        end
    endtask

    task automatic do_restart(int d, bit with_byte, byte unsigned b);
        @(negedge clk);
        drive(d, with_byte, b, 1'b1);
        model_restart(d);
        @(negedge clk);
        drive(d, 1'b0, 8'h00, 1'b0);
        check_status(d);
    endtask

    // done must appear exactly TMO edges after the edge that sampled the last byte
    task automatic wait_timeout(int d);
        int lim;
        lim = last_samp[d] + TMO - 1;
        while (cyc < lim) @(negedge clk);
        chk((d == 0) ? "A.busy_before_timeout" : "B.busy_before_timeout",
            64'((d == 0) ? bus_a.busy : bus_b.busy), 64'(1));
        @(negedge clk);
        model_timeout(d);
        check_status(d);
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (bus_a.mem_we === 1'b1) begin
            if (sb_a.size() == 0) begin
                chk("A.unexpected_we", 64'(1), 64'(0));
            end else begin
                w = sb_a.pop_front();
                $display("A write addr=%0h data=%0h cycle=%0d", bus_a.mem_addr, bus_a.mem_wdata, cyc);
                chk("A.mem_addr", 64'(bus_a.mem_addr), w.addr);
                chk("A.mem_wdata", 64'(bus_a.mem_wdata), w.data);
                chk("A.write_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
        if (bus_b.mem_we === 1'b1) begin
            if (sb_b.size() == 0) begin
                chk("B.unexpected_we", 64'(1), 64'(0));
            end else begin
                w = sb_b.pop_front();
                $display("B write addr=%0h data=%0h cycle=%0d", bus_b.mem_addr, bus_b.mem_wdata, cyc);
                chk("B.mem_addr", 64'(bus_b.mem_addr), w.addr);
                chk("B.mem_wdata", 64'(bus_b.mem_wdata), w.data);
                chk("B.write_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        model_restart(0);
        model_restart(1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_status(0);
        check_status(1);
        chk("A.mem_we_reset", 64'(bus_a.mem_we), 64'(0));
        chk("A.mem_addr_reset", 64'(bus_a.mem_addr), 64'(0));
        chk("A.mem_wdata_reset", 64'(bus_a.mem_wdata), 64'(0));
        chk("B.mem_wdata_reset", 64'(bus_b.mem_wdata), 64'(0));
        reset = 1'b0;

        // single 8-bit word, timeout to DONE, bytes ignored in DONE, restart
        send_str(0, "3A");
        wait_timeout(0);
        send_str(0, "99");
        do_restart(0, 1'b0, 8'h00);

        // 16-bit words with separators
        send_str(1, "12ab cd34\n");
        wait_timeout(1);
        do_restart(1, 1'b0, 8'h00);

        // separator mid-word resyncs
        send_str(0, "1 23");
        wait_timeout(0);
        do_restart(0, 1'b0, 8'h00);

        // invalid char drops partial; trailing partial hit by timeout
        send_str(0, "4G5");
        wait_timeout(0);
        do_restart(0, 1'b0, 8'h00);

        // invalid char in IDLE
        send_str(0, "x");
        do_restart(0, 1'b0, 8'h00);

        // memory full: fifth word overflows
        send_str(0, "01020304 05");
        do_restart(0, 1'b0, 8'h00);

        // XOR image, restart mid-word with a same-cycle byte that must be dropped
        send_str(0, "0FF0331");
        do_restart(0, 1'b1, 8'h35);
        send_str(0, "77");
        wait_timeout(0);

        repeat (3) @(negedge clk);
        chk("A.scoreboard_left", 64'(sb_a.size()), 64'(0));
        chk("B.scoreboard_left", 64'(sb_b.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
